simd_warp_exec: RTL and testbench
=================================

Name: simd_warp_exec

Overview:
Next-generation SIMD execution unit for the shader core. It issues one warp-instruction per cycle across LANES parallel integer ALUs. Each warp has its own per-lane register file, and a per-warp register scoreboard interlocks RAW/WAW hazards. It adds what the first-generation core lacked:
- valid/ready issue handshake
- per-lane predication mask
- fixed-latency pipelined writeback
- multi-warp register isolation
- debug read port and saturating performance counters

Parameters:
LANES, 16, parallel ALU lanes (power of 2, 1..32)
NUM_WARPS, 8, warps with private register files (power of 2, 2..32)
REGS, 32, registers per warp per lane (power of 2, 2..32); only the low log2(REGS) bits of register fields are used
DATA_W, 32, lane datapath width (16..32)
LATENCY, 3, issue-to-writeback pipeline depth (1..8)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
issue_valid  input  1  instruction offered
issue_ready  output  1  instruction accepted when issue_valid && issue_ready at rising edge
issue_warp  input  log2(NUM_WARPS)  target warp
issue_instr  input  32  [31:28] op, [27:23] dst, [22:18] src1, [17:13] src2, [12:0] imm13
issue_mask  input  LANES  per-lane write enable
wb_valid  output  1  writeback this cycle
wb_warp  output  log2(NUM_WARPS)  writeback warp
wb_dst  output  log2(REGS)  writeback register
wb_mask  output  LANES  lanes written
wb_data  output  LANES*DATA_W  results, lane i at [i*DATA_W +: DATA_W]
dbg_warp  input  log2(NUM_WARPS)  debug read warp
dbg_reg  input  log2(REGS)  debug read register
dbg_data  output  LANES*DATA_W  combinational register-file read
busy  output  1  any instruction in flight
pending_count  output  4  instructions in flight (0..LATENCY)
perf_issued  output  32  accepted instructions, saturating
perf_stall  output  32  cycles with issue_valid && !issue_ready, saturating

Behaviour:
- Reset (asynchronous, any time, including mid-flight):
  - All register files zero and the scoreboard cleared.
  - Pipeline valids dropped; in-flight results are discarded and never written.
  - Outputs: wb_valid=0, wb_* =0, busy=0, pending_count=0, perf counters=0.
- Opcodes (lane-wise, two's complement, results truncated to DATA_W):
  - 0 ADD, 1 SUB (src1-src2), 2 MUL (low DATA_W bits), 3 MIN signed, 4 MAX signed, 5 AND, 6 OR, 7 XOR.
  - 8 MOVI: imm13 sign-extended, broadcast to all lanes.
  - 9 LANEID: lane index, zero-extended.
  - 10-15 NOP: accepted and counted, no writeback, no scoreboard effect.
- Scoreboard: one pending bit per (warp, register).
  - issue_ready = !(pend[w][src1] | pend[w][src2] | pend[w][dst]) for non-NOP ops. This check is conservative: all three fields are checked for every op.
  - issue_ready=1 for NOP.
  - issue_ready is combinational on the issue inputs.
- Accept at edge k:
  - Operands are read from the register file before edge k.
  - pend[w][dst] is set at edge k (non-NOP).
  - mask, warp and dst travel with the instruction.
- Writeback:
  - wb_valid is high during the cycle following edge k+LATENCY-1.
  - The register file is written (masked lanes only) and pend cleared at edge k+LATENCY.
  - Unmasked lanes keep their old value.
  - A zero mask still occupies the scoreboard and asserts wb_valid with wb_mask=0.
- No bypass: a dependent instruction is accepted no earlier than edge k+LATENCY+1.
- Independent instructions, including the same register index in other warps, issue back-to-back at 1 per cycle.
- Setting one pending bit and clearing a different one at the same edge are both honoured. Set/clear of the same bit at the same edge cannot occur.
- dbg_data shows the value after the write edge, with no forwarding.
- Counters:
  - perf_issued increments per accept (NOPs included).
  - perf_stall increments per stalled cycle.
  - Both hold at 0xFFFFFFFF.
- pending_count: +1 on a non-NOP accept, -1 on a writeback edge, unchanged when both happen at once. busy = (pending_count != 0).

Test Plan:
1. Reset mid-flight: MOVI w0 r1=7, then assert rst_n low 1 cycle later -> wb_valid never rises, dbg w0 r1=0, pending_count=0, perf_issued=0.
2. LANEID w0 r1, MOVI w0 r2=5, NOP gap until clear, ADD w0 r3=r1+r2, full mask, LANES=16 -> dbg r3 lane i = i+5; wb_valid exactly 3 cycles after ADD accept.
3. RAW stall: ADD r3 accepted at edge k, then ADD w0 r4=r3+r3 held valid -> issue_ready low 3 cycles, accepted at edge k+4, perf_stall=3.
4. Predication: MOVI w0 r5=-1 with mask 0x00FF -> lanes 0-7 = 0xFFFFFFFF, lanes 8-15 = 0, wb_mask=0x00FF.
5. Warp isolation: MOVI w0 r1=1 then MOVI w1 r1=2 on consecutive edges -> no stall; w0 r1=1, w1 r1=2; pending_count peaks at 2.
6. Arithmetic edges: MOVI r1=-4096, MOVI r2=3, then MIN, MAX, MUL -> -4096, 3, 0xFFFFD000; SUB r2-r1 = 4099.

Source files
------------

// File: rtl/simd_warp_exec_if.sv
// Issue and writeback bundle of the SIMD warp execution unit. The master
// side offers instructions and consumes writebacks; the slave is the unit.
interface simd_warp_exec_if #(
  parameter int LANES     = 16,
  parameter int NUM_WARPS = 8,
  parameter int REGS      = 32,
  parameter int DATA_W    = 32
);
  logic                          issue_valid;
  logic                          issue_ready;
  logic [$clog2(NUM_WARPS)-1:0]  issue_warp;
  logic [31:0]                   issue_instr;
  logic [LANES-1:0]              issue_mask;

  logic                          wb_valid;
  logic [$clog2(NUM_WARPS)-1:0]  wb_warp;
  logic [$clog2(REGS)-1:0]       wb_dst;
  logic [LANES-1:0]              wb_mask;
  logic [LANES*DATA_W-1:0]       wb_data;

  modport master (
    output issue_valid, issue_warp, issue_instr, issue_mask,
    input  issue_ready, wb_valid, wb_warp, wb_dst, wb_mask, wb_data
  );

  modport slave (
    input  issue_valid, issue_warp, issue_instr, issue_mask,
    output issue_ready, wb_valid, wb_warp, wb_dst, wb_mask, wb_data
  );
endinterface

// File: rtl/simd_warp_exec.sv
// SIMD warp execution unit: per-warp register files, a per-(warp,reg)
// scoreboard, LANES integer ALUs and a fixed-depth writeback pipeline.
module simd_warp_exec #(
  parameter int LANES     = 16,
  parameter int NUM_WARPS = 8,
  parameter int REGS      = 32,
  parameter int DATA_W    = 32,
  parameter int LATENCY   = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  simd_warp_exec_if.slave               bus,
  input  logic [$clog2(NUM_WARPS)-1:0]  dbg_warp,
  input  logic [$clog2(REGS)-1:0]       dbg_reg,
  output logic [LANES*DATA_W-1:0]       dbg_data,
  output logic                          busy,
  output logic [3:0]                    pending_count,
  output logic [31:0]                   perf_issued,
  output logic [31:0]                   perf_stall
);
  localparam int WW = $clog2(NUM_WARPS);
  localparam int RW = $clog2(REGS);
  localparam int DW = LANES * DATA_W;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_MUL    = 4'd2,
    OP_MIN    = 4'd3,
    OP_MAX    = 4'd4,
    OP_AND    = 4'd5,
    OP_OR     = 4'd6,
    OP_XOR    = 4'd7,
    OP_MOVI   = 4'd8,
    OP_LANEID = 4'd9
  } op_e;

  typedef logic [DATA_W-1:0] lane_t;

  typedef struct packed {
    logic            valid;
    logic [WW-1:0]   warp;
    logic [RW-1:0]   dst;
    logic [LANES-1:0] mask;
    logic [DW-1:0]   data;
  } stage_t;

  lane_t          rf_q   [NUM_WARPS][REGS][LANES];
  lane_t          rf_d   [NUM_WARPS][REGS][LANES];
  logic [REGS-1:0] pend_q [NUM_WARPS];
  logic [REGS-1:0] pend_d [NUM_WARPS];
  stage_t         pipe_q [LATENCY];
  stage_t         pipe_d [LATENCY];
  logic [3:0]     pending_count_q, pending_count_d;
  logic [31:0]    perf_issued_q, perf_issued_d;
  logic [31:0]    perf_stall_q, perf_stall_d;

  logic [3:0]    op;
  logic [WW-1:0] iw;
  logic [RW-1:0] dst, src1, src2;
  logic [12:0]   imm;
  logic          is_nop, hazard, accept, issue_op;
  stage_t        wb;
  logic [DW-1:0] alu_res;

  // Only the low RW bits of each 5-bit register field are significant.
  assign op       = bus.issue_instr[31:28];
  assign dst      = bus.issue_instr[23 +: RW];
  assign src1     = bus.issue_instr[18 +: RW];
  assign src2     = bus.issue_instr[13 +: RW];
  assign imm      = bus.issue_instr[12:0];
  assign iw       = bus.issue_warp;
  assign is_nop   = (op > OP_LANEID);
  assign hazard   = pend_q[iw][src1] | pend_q[iw][src2] | pend_q[iw][dst];
  assign bus.issue_ready = is_nop | ~hazard;
  assign accept   = bus.issue_valid & bus.issue_ready;
  assign issue_op = accept & ~is_nop;
  assign wb       = pipe_q[LATENCY-1];

  // Operands come straight from the register file: there is no bypass path.
  always_comb begin
    alu_res = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_t a, b, r;
      a = rf_q[iw][src1][i];
      b = rf_q[iw][src2][i];
      case (op)
        OP_ADD:    r = a + b;
        OP_SUB:    r = a - b;
        OP_MUL:    r = a * b;
        OP_MIN:    r = ($signed(a) < $signed(b)) ? a : b;
        OP_MAX:    r = ($signed(a) > $signed(b)) ? a : b;
        OP_AND:    r = a & b;
        OP_OR:     r = a | b;
        OP_XOR:    r = a ^ b;
        OP_MOVI:   r = {{(DATA_W-13){imm[12]}}, imm};
        OP_LANEID: r = lane_t'(i);
        default:   r = '0;
      endcase
      alu_res[i*DATA_W +: DATA_W] = r;
    end
  end

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    rf_d            = rf_q;
    pend_d          = pend_q;
    pending_count_d = pending_count_q;
    perf_issued_d   = perf_issued_q;
    perf_stall_d    = perf_stall_q;

    if (wb.valid) begin
      pend_d[wb.warp][wb.dst] = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        if (wb.mask[i]) rf_d[wb.warp][wb.dst][i] = wb.data[i*DATA_W +: DATA_W];
      end
    end
    // Set and clear never target the same bit, so applying set last is safe.
    if (issue_op) pend_d[iw][dst] = 1'b1;

    pipe_d[0] = '0;
    if (issue_op) begin
      pipe_d[0].valid = 1'b1;
      pipe_d[0].warp  = iw;
      pipe_d[0].dst   = dst;
      pipe_d[0].mask  = bus.issue_mask;
      pipe_d[0].data  = alu_res;
    end
    for (int j = 1; j < LATENCY; j++) pipe_d[j] = pipe_q[j-1];

    case ({issue_op, wb.valid})
      2'b10:   pending_count_d = pending_count_q + 4'd1;
      2'b01:   pending_count_d = pending_count_q - 4'd1;
      default: pending_count_d = pending_count_q;
    endcase

    if (accept && perf_issued_q != '1) perf_issued_d = perf_issued_q + 32'd1;
    if (bus.issue_valid && !bus.issue_ready && perf_stall_q != '1)
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register file is reset too, because architected state must
      // read back as zero after reset; this is deliberate, not an oversight.
      rf_q            <= '{default: '0};
      pend_q          <= '{default: '0};
      pipe_q          <= '{default: '0};
      pending_count_q <= '0;
      perf_issued_q   <= '0;
      perf_stall_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      rf_q            <= rf_d;
      pend_q          <= pend_d;
      pipe_q          <= pipe_d;
      pending_count_q <= pending_count_d;
      perf_issued_q   <= perf_issued_d;
      perf_stall_q    <= perf_stall_d;
    end
  end

  assign bus.wb_valid = wb.valid;
  assign bus.wb_warp  = wb.warp;
  assign bus.wb_dst   = wb.dst;
  assign bus.wb_mask  = wb.mask;
  assign bus.wb_data  = wb.data;

  always_comb begin
    dbg_data = '0;
    for (int i = 0; i < LANES; i++) dbg_data[i*DATA_W +: DATA_W] = rf_q[dbg_warp][dbg_reg][i];
  end

  assign busy          = (pending_count_q != 4'd0);
  assign pending_count = pending_count_q;
  assign perf_issued   = perf_issued_q;
  assign perf_stall    = perf_stall_q;
endmodule

// File: tb/tb_simd_warp_exec.sv
// Directed bench for simd_warp_exec: reset, latency, hazards, predication,
// warp isolation, arithmetic corner cases and NOP handling.
module tb_simd_warp_exec;
  localparam int LANES = 16, NUM_WARPS = 8, REGS = 32, DATA_W = 32, LATENCY = 3;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, MIN = 4'd3, MAX = 4'd4;
  localparam logic [3:0] AND = 4'd5, OR = 4'd6, XOR = 4'd7, MOVI = 4'd8, LANEID = 4'd9;
  localparam logic [3:0] NOP = 4'd12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  simd_warp_exec_if #(.LANES(LANES), .NUM_WARPS(NUM_WARPS), .REGS(REGS), .DATA_W(DATA_W)) ifc ();

  logic [2:0]   dbg_warp;
  logic [4:0]   dbg_reg;
  logic [511:0] dbg_data;
  logic         busy;
  logic [3:0]   pending_count;
  logic [31:0]  perf_issued, perf_stall;

  simd_warp_exec #(
    .LANES(LANES), .NUM_WARPS(NUM_WARPS), .REGS(REGS), .DATA_W(DATA_W), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc),
    .dbg_warp(dbg_warp), .dbg_reg(dbg_reg), .dbg_data(dbg_data),
    .busy(busy), .pending_count(pending_count),
    .perf_issued(perf_issued), .perf_stall(perf_stall)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] d, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic [12:0] imm);
    return {op, d, s1, s2, imm};
  endfunction

  function automatic logic [31:0] lane_of(input logic [511:0] v, input int i);
    return v[i*32 +: 32];
  endfunction

  function automatic bit all_lanes(input logic [511:0] v, input logic [31:0] val);
    for (int i = 0; i < LANES; i++) if (v[i*32 +: 32] !== val) return 1'b0;
    return 1'b1;
  endfunction

  // Offers one instruction from the low clock phase and returns at the
  // falling edge after it was accepted, with issue_valid dropped.
  task automatic issue(input logic [2:0] w, input logic [31:0] ins, input logic [15:0] m,
                       output int stalls, output int acc);
    stalls = 0;
    ifc.issue_valid = 1'b1;
    ifc.issue_warp  = w;
    ifc.issue_instr = ins;
    ifc.issue_mask  = m;
    #1;
    while (!ifc.issue_ready && stalls < 40) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (!ifc.issue_ready) begin
      checks++; failures++;
      $display("FAIL issue_timeout: issue_ready=%b after %0d cycles, required 1", ifc.issue_ready, stalls);
    end
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    ifc.issue_valid = 1'b0;
  endtask

  task automatic wait_wb(output int n);
    n = 0;
    while (!ifc.wb_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ifc.wb_valid !== 1'b1) begin
      failures++;
      $display("FAIL wb_timeout: wb_valid=%b, required 1", ifc.wb_valid);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_timeout: busy=%b, required 0", busy);
    end
  endtask

  task automatic read_reg(input logic [2:0] w, input logic [4:0] r, output logic [511:0] v);
    dbg_warp = w;
    dbg_reg  = r;
    #1;
    v = dbg_data;
  endtask

  task automatic test_reset();
    int s, a, seen;
    logic [511:0] v;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ifc.wb_valid, busy, pending_count, perf_issued, perf_stall} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: wb_valid=%b busy=%b pend=%0d issued=%0d stall=%0d, required all 0",
               ifc.wb_valid, busy, pending_count, perf_issued, perf_stall);
    end
    issue(3'd0, mk(MOVI, 5'd1, 5'd0, 5'd0, 13'd7), 16'hFFFF, s, a);
    checks++;
    if (pending_count !== 4'd1) begin
      failures++;
      $display("FAIL reset_pre_inflight: pending_count=%0d, required 1", pending_count);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ifc.wb_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL reset_discard: wb_valid pulses=%0d, required 0", seen);
    end
    read_reg(3'd0, 5'd1, v);
    checks++;
    if (v !== '0 || pending_count !== 4'd0 || perf_issued !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: r1=%h pend=%0d issued=%0d, required 0 0 0", v[31:0], pending_count, perf_issued);
    end
  endtask

  task automatic test_laneid_add();
    int s, a, n, err;
    logic [511:0] v;
    issue(3'd0, mk(LANEID, 5'd1, 5'd0, 5'd0, 13'd0), 16'hFFFF, s, a);
    issue(3'd0, mk(MOVI, 5'd2, 5'd0, 5'd0, 13'd5), 16'hFFFF, s, a);
    wait_idle();
    issue(3'd0, mk(ADD, 5'd3, 5'd1, 5'd2, 13'd0), 16'hFFFF, s, a);
    wait_wb(n);
    checks++;
    if (n !== LATENCY - 1) begin
      failures++;
      $display("FAIL add_latency: wb after %0d edges past accept, required %0d", n, LATENCY - 1);
    end
    checks++;
    if (ifc.wb_warp !== 3'd0 || ifc.wb_dst !== 5'd3 || ifc.wb_mask !== 16'hFFFF) begin
      failures++;
      $display("FAIL add_wb_fields: warp=%0d dst=%0d mask=%h, required 0 3 ffff", ifc.wb_warp, ifc.wb_dst, ifc.wb_mask);
    end
    err = 0;
    for (int i = 0; i < LANES; i++) if (lane_of(ifc.wb_data, i) !== 32'(i + 5)) err++;
    checks++;
    if (err != 0) begin
      failures++;
      $display("FAIL add_wb_data: lane1=%h, required 00000006 (%0d bad lanes)", lane_of(ifc.wb_data, 1), err);
    end
    read_reg(3'd0, 5'd3, v);
    checks++;
    if (v !== '0) begin
      failures++;
      $display("FAIL no_forwarding: r3 lane0=%h during wb cycle, required 00000000", v[31:0]);
    end
    @(negedge clk);
    read_reg(3'd0, 5'd3, v);
    err = 0;
    for (int i = 0; i < LANES; i++) if (lane_of(v, i) !== 32'(i + 5)) err++;
    checks++;
    if (err != 0) begin
      failures++;
      $display("FAIL add_regfile: r3 lane15=%h, required 00000014 (%0d bad lanes)", lane_of(v, 15), err);
    end
  endtask

  task automatic test_raw_stall();
    int s, k, k2, err;
    logic [31:0] s0;
    logic [511:0] v;
    s0 = perf_stall;
    issue(3'd0, mk(ADD, 5'd3, 5'd1, 5'd2, 13'd0), 16'hFFFF, s, k);
    issue(3'd0, mk(ADD, 5'd4, 5'd3, 5'd3, 13'd0), 16'hFFFF, s, k2);
    checks++;
    if (s !== 3 || k2 !== k + 4) begin
      failures++;
      $display("FAIL raw_stall: stalls=%0d accept_delta=%0d, required 3 4", s, k2 - k);
    end
    checks++;
    if (perf_stall - s0 !== 32'd3) begin
      failures++;
      $display("FAIL perf_stall: delta=%0d, required 3", perf_stall - s0);
    end
    wait_idle();
    read_reg(3'd0, 5'd4, v);
    err = 0;
    for (int i = 0; i < LANES; i++) if (lane_of(v, i) !== 32'(2 * (i + 5))) err++;
    checks++;
    if (err != 0) begin
      failures++;
      $display("FAIL raw_result: r4 lane2=%h, required 0000000e (%0d bad lanes)", lane_of(v, 2), err);
    end
  endtask

  task automatic test_predication();
    int s, a, n, err;
    logic [511:0] v;
    issue(3'd0, mk(MOVI, 5'd5, 5'd0, 5'd0, 13'h1FFF), 16'h00FF, s, a);
    wait_wb(n);
    checks++;
    if (ifc.wb_mask !== 16'h00FF) begin
      failures++;
      $display("FAIL pred_wb_mask: wb_mask=%h, required 00ff", ifc.wb_mask);
    end
    @(negedge clk);
    read_reg(3'd0, 5'd5, v);
    err = 0;
    for (int i = 0; i < LANES; i++) if (lane_of(v, i) !== ((i < 8) ? 32'hFFFFFFFF : 32'h0)) err++;
    checks++;
    if (err != 0) begin
      failures++;
      $display("FAIL pred_lanes: lane0=%h lane8=%h, required ffffffff 00000000", lane_of(v, 0), lane_of(v, 8));
    end
    issue(3'd0, mk(MOVI, 5'd5, 5'd0, 5'd0, 13'd3), 16'h0000, s, a);
    wait_wb(n);
    checks++;
    if (ifc.wb_mask !== 16'h0000) begin
      failures++;
      $display("FAIL zero_mask_wb: wb_mask=%h, required 0000", ifc.wb_mask);
    end
    wait_idle();
    read_reg(3'd0, 5'd5, v);
    checks++;
    if (lane_of(v, 0) !== 32'hFFFFFFFF || lane_of(v, 8) !== 32'h0) begin
      failures++;
      $display("FAIL zero_mask_keep: lane0=%h lane8=%h, required ffffffff 00000000", lane_of(v, 0), lane_of(v, 8));
    end
  endtask

  task automatic test_warp_isolation();
    int s, a0, a1;
    logic [511:0] v0, v1;
    issue(3'd0, mk(MOVI, 5'd1, 5'd0, 5'd0, 13'd1), 16'hFFFF, s, a0);
    issue(3'd1, mk(MOVI, 5'd1, 5'd0, 5'd0, 13'd2), 16'hFFFF, s, a1);
    checks++;
    if (s !== 0 || a1 !== a0 + 1) begin
      failures++;
      $display("FAIL warp_back_to_back: stalls=%0d accept_delta=%0d, required 0 1", s, a1 - a0);
    end
    checks++;
    if (pending_count !== 4'd2) begin
      failures++;
      $display("FAIL warp_pending_peak: pending_count=%0d, required 2", pending_count);
    end
    wait_idle();
    read_reg(3'd0, 5'd1, v0);
    read_reg(3'd1, 5'd1, v1);
    checks++;
    if (!all_lanes(v0, 32'd1) || !all_lanes(v1, 32'd2)) begin
      failures++;
      $display("FAIL warp_isolation: w0r1=%h w1r1=%h, required 00000001 00000002", v0[31:0], v1[31:0]);
    end
  endtask

  task automatic test_arith_edges();
    int s, a, tot;
    logic [511:0] v;
    logic [31:0] exp_val [4];
    exp_val = '{32'hFFFFF000, 32'h00000003, 32'hFFFFD000, 32'h00001003};
    issue(3'd3, mk(MOVI, 5'd1, 5'd0, 5'd0, 13'h1000), 16'hFFFF, s, a);
    issue(3'd3, mk(MOVI, 5'd2, 5'd0, 5'd0, 13'd3), 16'hFFFF, s, a);
    wait_idle();
    tot = 0;
    issue(3'd3, mk(MIN, 5'd3, 5'd1, 5'd2, 13'd0), 16'hFFFF, s, a); tot += s;
    issue(3'd3, mk(MAX, 5'd4, 5'd1, 5'd2, 13'd0), 16'hFFFF, s, a); tot += s;
    issue(3'd3, mk(MUL, 5'd5, 5'd1, 5'd2, 13'd0), 16'hFFFF, s, a); tot += s;
    issue(3'd3, mk(SUB, 5'd6, 5'd2, 5'd1, 13'd0), 16'hFFFF, s, a); tot += s;
    checks++;
    if (tot !== 0) begin
      failures++;
      $display("FAIL arith_back_to_back: stalls=%0d, required 0", tot);
    end
    wait_idle();
    for (int r = 0; r < 4; r++) begin
      read_reg(3'd3, 5'(r + 3), v);
      checks++;
      if (!all_lanes(v, exp_val[r])) begin
        failures++;
        $display("FAIL arith_r%0d: lane0=%h, required %h", r + 3, v[31:0], exp_val[r]);
      end
    end
  endtask

  task automatic test_logic_ops();
    int s, a, err;
    logic [511:0] va, vo, vx;
    issue(3'd2, mk(LANEID, 5'd1, 5'd0, 5'd0, 13'd0), 16'hFFFF, s, a);
    issue(3'd2, mk(MOVI, 5'd2, 5'd0, 5'd0, 13'd5), 16'hFFFF, s, a);
    wait_idle();
    issue(3'd2, mk(AND, 5'd3, 5'd1, 5'd2, 13'd0), 16'hFFFF, s, a);
    issue(3'd2, mk(OR, 5'd4, 5'd1, 5'd2, 13'd0), 16'hFFFF, s, a);
    issue(3'd2, mk(XOR, 5'd5, 5'd1, 5'd2, 13'd0), 16'hFFFF, s, a);
    wait_idle();
    read_reg(3'd2, 5'd3, va);
    read_reg(3'd2, 5'd4, vo);
    read_reg(3'd2, 5'd5, vx);
    err = 0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_of(va, i) !== 32'(i & 5)) err++;
      if (lane_of(vo, i) !== 32'(i | 5)) err++;
      if (lane_of(vx, i) !== 32'(i ^ 5)) err++;
    end
    checks++;
    if (err != 0) begin
      failures++;
      $display("FAIL logic_ops: lane6 and=%h or=%h xor=%h, required 4 7 3",
               lane_of(va, 6), lane_of(vo, 6), lane_of(vx, 6));
    end
  endtask

  task automatic test_nop();
    int s, a, seen;
    logic [31:0] i0;
    i0 = perf_issued;
    issue(3'd4, mk(MOVI, 5'd1, 5'd0, 5'd0, 13'd9), 16'hFFFF, s, a);
    issue(3'd4, mk(NOP, 5'd1, 5'd1, 5'd1, 13'd0), 16'hFFFF, s, a);
    checks++;
    if (s !== 0 || pending_count !== 4'd1) begin
      failures++;
      $display("FAIL nop_issue: stalls=%0d pending=%0d, required 0 1", s, pending_count);
    end
    checks++;
    if (perf_issued - i0 !== 32'd2) begin
      failures++;
      $display("FAIL nop_counted: perf_issued delta=%0d, required 2", perf_issued - i0);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (ifc.wb_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL nop_no_wb: wb pulses=%0d busy=%b, required 1 0", seen, busy);
    end
  endtask

  initial begin
    ifc.issue_valid = 1'b0;
    ifc.issue_warp  = '0;
    ifc.issue_instr = '0;
    ifc.issue_mask  = '0;
    dbg_warp = '0;
    dbg_reg  = '0;
    test_reset();
    test_laneid_add();
    test_raw_stall();
    test_predication();
    test_warp_isolation();
    test_arith_edges();
    test_logic_ops();
    test_nop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
